seq_rom_bcd_display: RTL and testbench

SEQ_ROM_BCD_DISPLAY -- requirements
Module: seq_rom_bcd_display

---
 rtl/seq_rom_bcd_display.sv | 129 ++++++++++++
 tb/tb_seq_rom_bcd_display.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/seq_rom_bcd_display.sv
// seq_rom_bcd_display: looks up a switch-selected word in an external synchronous ROM,
// converts it to decimal with double-dabble and drives active-low 7-segment digits.
module seq_rom_bcd_display #(
   parameter int ADDR_W = 10,
   parameter int DATA_W = 10,
   parameter int DIGITS = 5
) (
   input  logic                CLOCK_50,
   input  logic                RST_N,
   input  logic [ADDR_W-1:0]   SW,
   input  logic                HOLD,
   input  logic                BLANK_EN,
   output logic [ADDR_W-1:0]   ROM_ADDR,
   input  logic [DATA_W-1:0]   ROM_DATA,
   output logic [7*DIGITS-1:0] HEX,
   output logic                BUSY,
   output logic                DONE
);
   localparam int CW = $clog2(DATA_W + 1);
   localparam logic [2:0] IDLE = 3'd0, FETCH = 3'd1, CAPTURE = 3'd2, CONVERT = 3'd3, UPDATE = 3'd4;

   function automatic logic [63:0] f_pow10(input int n);
      logic [63:0] p;
      p = 64'd1;
      for (int i = 0; i < n; i++) p = p * 64'd10;
      return p;
   endfunction

   generate
      if (f_pow10(DIGITS) < (64'd1 << DATA_W)) begin : g_bad_digits
         $error("DIGITS too small to hold every DATA_W value in decimal");
      end
   endgenerate

   function automatic logic [6:0] f_seg(input logic [3:0] d);
      case (d)
         4'd0: return 7'b1000000;
         4'd1: return 7'b1111001;
         4'd2: return 7'b0100100;
         4'd3: return 7'b0110000;
         4'd4: return 7'b0011001;
         4'd5: return 7'b0010010;
         4'd6: return 7'b0000010;
         4'd7: return 7'b1111000;
         4'd8: return 7'b0000000;
         4'd9: return 7'b0010000;
         default: return 7'b1111111;
      endcase
   endfunction

   logic [2:0]          r_state;
   logic [ADDR_W-1:0]   r_sw_m, r_sw_s, r_last, r_rom_addr;
   logic                r_first, r_busy, r_done;
   logic [DATA_W-1:0]   r_bin;
   logic [4*DIGITS-1:0] r_bcd, w_adj;
   logic [CW-1:0]       r_cnt;
   logic [7*DIGITS-1:0] r_hex, w_hex;

   assign ROM_ADDR = r_rom_addr;
   assign HEX      = r_hex;
   assign BUSY     = r_busy;
   assign DONE     = r_done;

   always_comb begin
      w_adj = '0;
      for (int k = 0; k < DIGITS; k++)
         w_adj[4*k +: 4] = (r_bcd[4*k +: 4] >= 4'd5) ? r_bcd[4*k +: 4] + 4'd3 : r_bcd[4*k +: 4];
   end

   // Walk from the top digit down; a digit is a leading zero while every digit above it is zero.
   always_comb begin
      logic w_lead;
      w_lead = 1'b1;
      w_hex  = '1;
      for (int k = DIGITS - 1; k >= 0; k--) begin
         w_lead = w_lead && (r_bcd[4*k +: 4] == 4'd0) && (k != 0);
         w_hex[7*k +: 7] = (BLANK_EN && w_lead) ? 7'h7f : f_seg(r_bcd[4*k +: 4]);
      end
   end

   always_ff @(posedge CLOCK_50 or negedge RST_N) begin
      if (!RST_N) begin
         r_state    <= IDLE;
         r_sw_m     <= '0;
         r_sw_s     <= '0;
         r_last     <= '0;
         r_rom_addr <= '0;
         r_first    <= 1'b1;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
         r_bin      <= '0;
         r_bcd      <= '0;
         r_cnt      <= '0;
         r_hex      <= '1;
      end else begin
         r_sw_m <= SW;
         r_sw_s <= r_sw_m;
         r_done <= 1'b0;
         case (r_state)
            IDLE: if (!HOLD && (r_sw_s != r_last || r_first)) begin
               r_rom_addr <= r_sw_s;
               r_last     <= r_sw_s;
               r_first    <= 1'b0;
               r_busy     <= 1'b1;
               r_state    <= FETCH;
            end
            FETCH: r_state <= CAPTURE;
            CAPTURE: begin
               r_bin   <= ROM_DATA;
               r_bcd   <= '0;
               r_cnt   <= '0;
               r_state <= CONVERT;
            end
            CONVERT: begin
               {r_bcd, r_bin} <= {w_adj, r_bin} << 1;
               r_cnt          <= r_cnt + 1'b1;
               if (r_cnt == CW'(DATA_W - 1)) r_state <= UPDATE;
            end
            UPDATE: begin
               r_hex   <= w_hex;
               r_done  <= 1'b1;
               r_busy  <= 1'b0;
               r_state <= IDLE;
            end
            default: r_state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_seq_rom_bcd_display.sv
// tb_seq_rom_bcd_display: directed and randomized lookups against a decimal/segment reference model,
// with a second 14-bit-data instance for the wide configuration.
module tb_seq_rom_bcd_display;
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n = 1'b1, hold = 1'b1, blank = 1'b0;
   logic [9:0]  sw = '0, rom_addr, rom_data;
   logic [34:0] hex, hex2;
   logic        busy, done, busy2, done2;
   logic [3:0]  sw2 = '0, rom_addr2;
   logic [13:0] rom_data2;
   logic [9:0]  rom [1024];
   logic [13:0] rom2 [16];
   logic [6:0]  seg [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                             7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};
   int checks = 0, errors = 0, n = 0, done_cnt = 0;

   seq_rom_bcd_display u_dut (
      .CLOCK_50(clk), .RST_N(rst_n), .SW(sw), .HOLD(hold), .BLANK_EN(blank),
      .ROM_ADDR(rom_addr), .ROM_DATA(rom_data), .HEX(hex), .BUSY(busy), .DONE(done));

   seq_rom_bcd_display #(.ADDR_W(4), .DATA_W(14), .DIGITS(5)) u_wide (
      .CLOCK_50(clk), .RST_N(rst_n), .SW(sw2), .HOLD(1'b0), .BLANK_EN(blank),
      .ROM_ADDR(rom_addr2), .ROM_DATA(rom_data2), .HEX(hex2), .BUSY(busy2), .DONE(done2));

   always @(posedge clk) begin
      rom_data  <= rom[rom_addr];
      rom_data2 <= rom2[rom_addr2];
      if (done) done_cnt <= done_cnt + 1;
   end

   function automatic logic [34:0] model(input logic [63:0] v, input bit bl);
      logic [34:0] h;
      logic [63:0] t;
      int nd;
      nd = 1;
      t  = v / 10;
      while (t != 0) begin nd++; t = t / 10; end
      t = v;
      for (int k = 0; k < 5; k++) begin
         h[7*k +: 7] = (bl && k >= nd) ? 7'h7f : seg[t % 10];
         t = t / 10;
      end
      return h;
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
      n++;
   endtask

   task automatic wait_start(input int w);
      int k;
      k = 0;
      n = 0;
      while (((w != 0) ? busy2 : busy) !== 1'b1 && k < 60) begin @(negedge clk); k++; end
      chk("start_seen", (w != 0) ? busy2 : busy, 1);
   endtask

   task automatic finish(input int w, input int a, input bit bl);
      logic [63:0] v;
      v = (w != 0) ? 64'(rom2[a]) : 64'(rom[a]);
      while (((w != 0) ? done2 : done) !== 1'b1 && n < 100) tick();
      chk("latency", n, (w != 0) ? 17 : 13);
      chk("hex", (w != 0) ? hex2 : hex, model(v, bl));
      chk("rom_addr", (w != 0) ? 10'(rom_addr2) : rom_addr, a);
      chk("busy_clr", (w != 0) ? busy2 : busy, 0);
      tick();
      chk("done_pulse", (w != 0) ? done2 : done, 0);
   endtask

   // Assert reset at the current time, release with HOLD high, then allow lookups.
   task automatic reset_dut();
      rst_n = 1'b0;
      hold  = 1'b1;
      #1;
      chk("rst_hex", hex, 64'h7_ffff_ffff);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_addr", rom_addr, 0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      chk("held_busy", busy, 0);
      hold = 1'b0;
   endtask

   initial begin
      int a, d0;
      bit bl, pbl;
      logic [34:0] prev;
      for (int i = 0; i < 1024; i++) rom[i] = 10'($urandom_range(0, 1023));
      for (int i = 0; i < 16; i++) rom2[i] = 14'($urandom_range(0, 16383));
      rom[0] = 10'd407; rom[5] = 10'd1023; rom[8] = 10'd1023; rom[9] = 10'd0; rom[7] = 10'd42;
      rom2[3] = 14'd16383;
      #1;
      reset_dut();
      wait_start(0);
      finish(0, 0, 0);
      sw = 10'd5;
      @(negedge clk);
      reset_dut();
      wait_start(0);
      finish(0, 5, 0);
      chk("hex_1023", hex, {7'b1000000, 7'b1111001, 7'b1000000, 7'b0100100, 7'b0110000});
      blank = 1'b1; sw = 10'd8;
      wait_start(0);
      finish(0, 8, 1);
      chk("hex_1023_blank", hex, {7'b1111111, 7'b1111001, 7'b1000000, 7'b0100100, 7'b0110000});
      sw = 10'd9;
      wait_start(0);
      finish(0, 9, 1);
      chk("hex_zero_blank", hex, {{4{7'b1111111}}, 7'b1000000});
      hold = 1'b1; blank = 1'b0; sw = 10'd6;
      repeat (12) tick();
      chk("hold_busy", busy, 0);
      chk("hold_hex", hex, model(rom[9], 1));
      hold = 1'b0;
      wait_start(0);
      finish(0, 6, 0);
      d0 = done_cnt;
      sw = 10'd5;
      wait_start(0);
      repeat (5) tick();
      chk("mid_hex", hex, model(rom[6], 0));
      sw = 10'd7;
      finish(0, 5, 0);
      wait_start(0);
      finish(0, 7, 0);
      repeat (20) tick();
      chk("two_done", done_cnt - d0, 2);
      chk("idle_busy", busy, 0);
      sw = 10'd1;
      wait_start(0);
      repeat (6) tick();
      reset_dut();
      wait_start(0);
      finish(0, 1, 0);
      prev = model(rom[1], 0);
      pbl = 1'b0;
      for (int it = 0; it < 10; it++) begin
         do a = $urandom_range(0, 1023); while (a == int'(sw));
         bl = 1'($urandom_range(0, 1));
         sw = 10'(a); blank = bl;
         wait_start(0);
         repeat ($urandom_range(3, 10)) tick();
         chk("rand_mid_hex", hex, prev);
         hold = 1'($urandom_range(0, 1));
         finish(0, a, bl);
         hold = 1'b0;
         prev = model(rom[a], bl);
         pbl = bl;
      end
      blank = 1'b0; sw2 = 4'd3;
      wait_start(1);
      finish(1, 3, 0);
      chk("wide_16383", hex2, {7'b1111001, 7'b0000010, 7'b0110000, 7'b0000000, 7'b0110000});
      for (int it = 0; it < 5; it++) begin
         do a = $urandom_range(0, 15); while (a == int'(sw2));
         bl = 1'($urandom_range(0, 1));
         sw2 = 4'(a); blank = bl;
         wait_start(1);
         finish(1, a, bl);
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
